// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Bundles the byte-source handshake and the mux-facing outputs of the UART
// transmitter control stage.
//
// Handshake: the source presents P_DATA/PAR_EN/PAR_TYP with Data_Valid.
// A byte is accepted on the rising edge where Data_Valid=1 and the controller
// is idle (busy=0). Data_Valid is ignored while busy=1. Frames are always
// separated by at least one idle cycle.
//
// Signals:
//   P_DATA      parallel byte to send (LSB first)
//   Data_Valid  P_DATA valid strobe
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   mux_sel     00 idle/stop, 01 start, 10 data, 11 parity
//   ser_data    current serial data bit
//   parity_data parity bit of the latched byte
//   busy        frame in progress
//
// Modports: master = byte source / bench, slave = uart_tx_ctrl.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  parity_data;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, parity_data, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, parity_data, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Frame state machine and datapath of the UART transmitter. Accepts a byte
// while idle, then walks START -> DATA (DATA_WIDTH cycles) -> PARITY (when
// enabled) -> STOP -> IDLE, one bit per clock. Drives the TX mux select, the
// serial data bit and the parity bit.
//
// Ports:
//   CLK        TX bit clock
//   RST        asynchronous active-low reset
//   bus        uart_tx_ctrl_if.slave (byte handshake + mux-facing outputs)
//   state_dbg  current FSM state encoding (IDLE=0 START=1 DATA=2 PARITY=3
//              STOP=4), for observation only
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_ctrl_if.slave      bus,
    output logic [2:0]         state_dbg
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;

    // Everything is cleared asynchronously so an abort mid-frame drops the
    // line to idle (mux_sel=00) without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        parity_d = parity_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    shift_d  = bus.P_DATA;
                    par_en_d = bus.PAR_EN;
                    // Parity type only matters at acceptance, so it is folded
                    // straight into the registered parity bit.
                    parity_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        bus.mux_sel = 2'b00;
        bus.busy    = 1'b1;
        unique case (state_q)
            S_IDLE:   begin bus.mux_sel = 2'b00; bus.busy = 1'b0; end
            S_START:  bus.mux_sel = 2'b01;
            S_DATA:   bus.mux_sel = 2'b10;
            S_PARITY: bus.mux_sel = 2'b11;
            S_STOP:   bus.mux_sel = 2'b00;
            default:  begin bus.mux_sel = 2'b00; bus.busy = 1'b0; end
        endcase
    end

    assign bus.ser_data    = shift_q[0];
    assign bus.parity_data = parity_q;
    assign state_dbg       = state_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Control and datapath stage of the UART transmitter, directly upstream of the TX output multiplexer. It accepts a parallel byte with a valid strobe and runs the frame state machine (start, data, optional parity, stop). It drives the mux select, the serialized data bit and the computed parity bit that the mux turns into the TX line. It reports busy to the upstream data source, which is the async FIFO / system controller side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first.

Ports:
CLK  input  1  TX clock (oversample-free; one bit per cycle)
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel data to transmit
Data_Valid  input  1  P_DATA valid; accepted only when idle
PAR_EN  input  1  1 = parity bit included in frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
mux_sel  output  2  00 idle/stop (line 1), 01 start (line 0), 10 data, 11 parity
ser_data  output  1  current data bit
parity_data  output  1  parity bit of latched byte
busy  output  1  frame in progress

Behaviour:
- Reset (RST low, asynchronous): state IDLE, shift register 0, bit counter 0, latched PAR_EN/PAR_TYP 0, parity_data 0, ser_data 0, busy 0, mux_sel 00.
- Reset asserted mid-frame aborts the frame immediately. mux_sel returns to 00 (line high) without waiting for a clock. No residual state survives.
- FSM states: IDLE, START, DATA, PARITY, STOP. mux_sel and busy are Moore outputs decoded from state.
  - busy = 1 in every state except IDLE.
  - mux_sel = 00 in IDLE and STOP; 01 in START; 10 in DATA; 11 in PARITY.
- IDLE: if Data_Valid = 1 at a rising edge, latch P_DATA, PAR_EN and PAR_TYP, compute parity, and go to START. Otherwise stay in IDLE.
- Data_Valid is ignored in every other state. Input changes during a frame do not affect it.
- START: lasts 1 cycle, then DATA.
- DATA: lasts DATA_WIDTH cycles.
  - ser_data = shift register bit 0.
  - The register shifts right once per cycle, and the bit counter increments.
  - When the counter reaches DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else to STOP. The counter clears to 0.
- PARITY: lasts 1 cycle, then STOP.
- STOP: lasts 1 cycle, then IDLE. Back-to-back acceptance directly from STOP is not supported; at least one IDLE cycle separates frames.
- Parity: parity_data = XOR-reduce(latched data) when PAR_TYP = 0, and its complement when PAR_TYP = 1.
  - Registered at acceptance.
  - Held constant from START through STOP.
  - Holds its last value in IDLE.
- ser_data outside DATA equals shift register bit 0 and is don't-care to the mux.
- Timing, with cycle 0 = the IDLE cycle in which Data_Valid is sampled:
  - cycle 1 START;
  - cycles 2..DATA_WIDTH+1 DATA;
  - then PARITY (if enabled);
  - then STOP;
  - then IDLE.
  - Frame = DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- Counter width = clog2(DATA_WIDTH). No wrap-around beyond DATA_WIDTH-1 is permitted.

Test Plan:
1. Reset then idle: hold RST low 2 cycles, release, Data_Valid=0 for 5 cycles -> mux_sel=00, busy=0, parity_data=0 throughout.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> mux_sel sequence 01, then 10 x8, 11, 00.
   - ser_data during DATA = 1,0,1,0,0,1,0,1.
   - parity_data=0.
   - busy high for exactly 11 cycles.
3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> same sequence, parity_data=1. Then P_DATA=0x01, PAR_TYP=0 -> parity_data=1.
4. P_DATA=0x3C, PAR_EN=0 -> mux_sel 01, 10 x8, 00. Mux_sel never equals 11. Busy high for 10 cycles.
5. Continuous Data_Valid=1 while P_DATA changes each cycle -> the second frame's START occurs exactly one IDLE cycle after STOP. The second frame carries the P_DATA present in that IDLE cycle, and the first frame's bits are unaffected by mid-frame changes.
6. Assert RST low during DATA cycle 4 of a 0xFF frame -> mux_sel=00 and busy=0 immediately, before the next clock edge. After release, a new 0x00 frame transmits cleanly with ser_data=0 x8 and even parity_data=0.
